// File: rtl/sram_id_lookup_ctrl.sv
// Single-transaction ID lookup/insert sequencer over one SRAM row and the 14-way ID comparator.
// Optional statistics counters are built when SRAM_ID_LOOKUP_STATS_EN is defined.
module sram_id_lookup_ctrl #(
  parameter int NUM_SLOTS  = 14,
  parameter int ID_W       = 16,
  parameter int ADDR_W     = 19,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ID_W-1:0]           req_id,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic                      req_insert,
  output logic                      sram_rd_en,
  output logic [ADDR_W-1:0]         sram_rd_addr,
  input  logic                      sram_rd_valid,
  input  logic [NUM_SLOTS*ID_W-1:0] sram_rd_data,
  output logic                      sram_wr_en,
  output logic [ADDR_W-1:0]         sram_wr_addr,
  output logic [3:0]                sram_wr_slot,
  output logic [ID_W-1:0]           sram_wr_data,
  output logic [NUM_SLOTS-1:0]      cmp_ena,
  output logic [NUM_SLOTS*ID_W-1:0] cmp_id_data,
  output logic [ID_W-1:0]           cmp_packet_id,
  input  logic [2*NUM_SLOTS-1:0]    cmp_result,
`ifdef SRAM_ID_LOOKUP_STATS_EN
  input  logic                      stat_clear,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_inserts,
  output logic [31:0]               stat_full,
  output logic [31:0]               stat_timeouts,
`endif
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [2:0]                resp_status,
  output logic [3:0]                resp_slot
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [2:0] ST_HIT       = 3'd0;
  localparam logic [2:0] ST_INSERTED  = 3'd1;
  localparam logic [2:0] ST_MISS_FREE = 3'd2;
  localparam logic [2:0] ST_FULL      = 3'd3;
  localparam logic [2:0] ST_TIMEOUT   = 3'd4;
  localparam logic [2:0] ST_BAD_ID    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT_RD, S_CMP, S_RESOLVE, S_WR, S_RESP
  } state_t;

  state_t                      state_q, state_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        insert_q, insert_d;
  logic [NUM_SLOTS*ID_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  status_q, status_d;
  logic [3:0]                  slot_q, slot_d;

  logic                        hit_found, free_found;
  logic [3:0]                  hit_idx, free_idx;

  // Descending scan so the lowest matching slot is the one that sticks; code 3 decodes as nothing.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (cmp_result[2*k +: 2] == 2'd1) begin
        hit_found = 1'b1;
        hit_idx   = 4'(k);
      end
      if (cmp_result[2*k +: 2] == 2'd2) begin
        free_found = 1'b1;
        free_idx   = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      insert_q <= 1'b0;
      row_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      insert_q <= insert_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    insert_d = insert_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    slot_d   = slot_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          id_d     = req_id;
          addr_d   = req_addr;
          insert_d = req_insert;
          if (req_id == '0) begin
            status_d = ST_BAD_ID;
            slot_d   = '0;
            state_d  = S_RESP;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (sram_rd_valid) begin
          row_d   = sram_rd_data;
          state_d = S_CMP;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          slot_d   = '0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CMP: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        // A match always beats an empty slot.
        if (hit_found) begin
          status_d = ST_HIT;
          slot_d   = hit_idx;
          state_d  = S_RESP;
        end else if (free_found) begin
          slot_d = free_idx;
          if (insert_q) begin
            status_d = ST_INSERTED;
            state_d  = S_WR;
          end else begin
            status_d = ST_MISS_FREE;
            state_d  = S_RESP;
          end
        end else begin
          status_d = ST_FULL;
          slot_d   = '0;
          state_d  = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready     = (state_q == S_IDLE);
  assign sram_rd_en    = (state_q == S_RD);
  assign sram_rd_addr  = addr_q;
  assign sram_wr_en    = (state_q == S_WR);
  assign sram_wr_addr  = addr_q;
  assign sram_wr_slot  = slot_q;
  assign sram_wr_data  = id_q;
  assign cmp_ena       = (state_q == S_CMP) ? '1 : '0;
  assign cmp_id_data   = row_q;
  assign cmp_packet_id = id_q;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_status   = status_q;
  assign resp_slot     = slot_q;

`ifdef SRAM_ID_LOOKUP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        xfer;
  logic [31:0] hits_q, inserts_q, full_q, timeouts_q;

  assign xfer = (state_q == S_RESP) && resp_ready;

  // Clear takes priority over a same-cycle response transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q     <= '0;
      inserts_q  <= '0;
      full_q     <= '0;
      timeouts_q <= '0;
    end else if (stat_clear) begin
      hits_q     <= '0;
      inserts_q  <= '0;
      full_q     <= '0;
      timeouts_q <= '0;
    end else if (xfer) begin
      if (status_q == ST_HIT)      hits_q     <= sat_inc(hits_q);
      if (status_q == ST_INSERTED) inserts_q  <= sat_inc(inserts_q);
      if (status_q == ST_FULL)     full_q     <= sat_inc(full_q);
      if (status_q == ST_TIMEOUT)  timeouts_q <= sat_inc(timeouts_q);
    end
  end

  assign stat_hits     = hits_q;
  assign stat_inserts  = inserts_q;
  assign stat_full     = full_q;
  assign stat_timeouts = timeouts_q;
`endif

endmodule

// File: doc/sram_id_lookup_ctrl.md
Name: sram_id_lookup_ctrl

Overview:
Sequences one ID lookup/insert transaction over a 14-slot SRAM ID row using the existing 14-way per-slot ID comparator (registered, 2-bit result per slot: 0 none, 1 match, 2 empty).
Accepts a request (ID, row address, insert flag) and reads the row from SRAM. It drives the comparator for one cycle, then priority-resolves hit or first free slot. On an insert it writes the ID back to SRAM, then returns a status response.
Sits between the packet parser and the SRAM process-table port.

Parameters:
NUM_SLOTS, 14, slots per row; fixed to comparator width.
ID_W, 16, ID width.
ADDR_W, 19, SRAM row address width.
RD_TIMEOUT, 64, max cycles waiting for sram_rd_valid; must be ≥2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_id  in  ID_W  packet ID to look up
req_addr  in  ADDR_W  SRAM row address
req_insert  in  1  insert on miss if free slot exists
sram_rd_en  out  1  one-cycle read strobe
sram_rd_addr  out  ADDR_W  read row address
sram_rd_valid  in  1  read data valid (single-cycle)
sram_rd_data  in  NUM_SLOTS*ID_W  row; slot k at bits [k*16+15:k*16]
sram_wr_en  out  1  one-cycle write strobe
sram_wr_addr  out  ADDR_W  write row address
sram_wr_slot  out  4  slot index written
sram_wr_data  out  ID_W  ID written
cmp_ena  out  NUM_SLOTS  comparator enables
cmp_id_data  out  NUM_SLOTS*ID_W  captured row to comparator
cmp_packet_id  out  ID_W  ID to comparator
cmp_result  in  2*NUM_SLOTS  comparator results; slot k at [2k+1:2k]
resp_valid  out  1  response valid, held until accepted
resp_ready  in  1  response accept
resp_status  out  3  0 HIT, 1 INSERTED, 2 MISS_FREE, 3 FULL, 4 TIMEOUT, 5 BAD_ID
resp_slot  out  4  hit/inserted/free slot index, else 0

Behaviour:
- Reset (async, active-low): state IDLE, all strobes 0, cmp_ena 0, resp_valid 0, resp_status 0, resp_slot 0, captured row/ID/addr 0.
- States: IDLE, RD, WAIT_RD, CMP, RESOLVE, WR, RESP.
- IDLE: req_ready=1. On req_valid, capture req_id/addr/insert.
  - If req_id==0 → RESP with BAD_ID; no SRAM access.
  - Else → RD.
- RD: sram_rd_en=1 for exactly 1 cycle, sram_rd_addr=captured addr; clear timeout counter → WAIT_RD.
- WAIT_RD: count cycles.
  - On sram_rd_valid, latch sram_rd_data into row register → CMP.
  - If the count reaches RD_TIMEOUT without sram_rd_valid → RESP with TIMEOUT, slot 0.
  - sram_rd_valid outside WAIT_RD is ignored.
- CMP: cmp_ena all ones for exactly 1 cycle; cmp_id_data = row register; cmp_packet_id = captured ID (held stable from capture until IDLE) → RESOLVE.
- RESOLVE: sample cmp_result, which is the comparator's registered output from the CMP cycle.
  - Lowest-index slot with result 1 → HIT.
  - Else lowest-index slot with result 2: insert=1 → WR; insert=0 → MISS_FREE.
  - Else → FULL.
  - Result 3 is treated as 0.
- WR: sram_wr_en=1 for 1 cycle, sram_wr_addr = captured addr, sram_wr_slot = free slot, sram_wr_data = captured ID → RESP with INSERTED.
- RESP: resp_valid=1; status/slot stable until resp_ready. Transfer on resp_valid&resp_ready → IDLE, resp_valid=0 the next cycle.
- Outside CMP, cmp_ena=0.
- Latency for a hit with 1-cycle SRAM read (accept to resp_valid): 5 cycles. Insert adds 1.
- Only one transaction in flight; a request during non-IDLE is not accepted (req_ready=0).
- Reset mid-transaction aborts immediately. No write is issued, and a pending response is lost.

Optional Feature:
SRAM_ID_LOOKUP_STATS_EN.
- Defined: adds outputs stat_hits, stat_inserts, stat_full, stat_timeouts (32 bits each, saturating at 0xFFFFFFFF) and input stat_clear.
  - Each counter increments by 1 on the cycle its response transfers.
  - stat_clear zeroes all counters; if a response transfers in the same cycle as stat_clear, the clear wins.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Row slot 5=0x1234, others nonzero ≠ID; req_id=0x1234 → one sram_rd_en pulse, cmp_ena=0x3FFF for 1 cycle, resp HIT slot 5, no sram_wr_en.
- Slots 3 and 9 = 0, no match, req_insert=1, req_id=0xBEEF → sram_wr_en pulse with slot 3, data 0xBEEF; resp INSERTED slot 3.
- Slot 2=0, slot 7=ID → HIT slot 7 (match beats empty). Same row, insert=0, ID absent → MISS_FREE slot 2, no write.
- All slots nonzero, no match, insert=1 → FULL, slot 0, no write.
- sram_rd_valid withheld for 64 cycles → TIMEOUT. Also req_id=0 → BAD_ID with no sram_rd_en. resp_ready held low 10 cycles → resp fields stable, req_ready=0 throughout.
- Assert reset in WAIT_RD, then release → all outputs at reset values. A new request then completes normally.
